// File: rtl/i2c_slave_write_receiver.sv
// rtl/i2c_slave_write_receiver.sv - I2C target receiving register writes (write-only, auto-increment)
module i2c_slave_write_receiver #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_write,
  output logic       busy,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t     state, state_next;
  logic       scl_meta, scl_sync, scl_prev;
  logic       sda_meta, sda_sync, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       bit_pending, bit_pending_next;
  logic [6:0] shift, shift_next;
  logic [7:0] byte_in;
  logic       sda_next, write_next, busy_next;
  logic [7:0] addr_next, data_next, status_next;
  logic       byte_state, abort;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign byte_in   = {shift, sda_sync};

  // The SCL pulse carrying START/STOP has already sampled a bit that never completes;
  // only bits closed by a falling edge count towards an abort.
  assign byte_state = (state == ADDR) || (state == REG) || (state == DATA);
  assign abort      = byte_state && (bit_cnt != {2'b00, bit_pending});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    bit_pending_next = bit_pending;
    shift_next       = shift;
    sda_next         = sda_drive_low;
    addr_next        = reg_addr;
    data_next        = reg_data;
    write_next       = 1'b0;
    busy_next        = busy;
    status_next      = status;

    if (start_det) begin
      state_next       = ADDR;
      busy_next        = 1'b1;
      status_next      = abort ? 8'h10 : 8'h00;
      bit_cnt_next     = 3'd0;
      bit_pending_next = 1'b0;
      sda_next         = 1'b0;
    end else if (stop_det) begin
      state_next       = IDLE;
      busy_next        = 1'b0;
      status_next      = abort ? (status | 8'h10) : status;
      bit_cnt_next     = 3'd0;
      bit_pending_next = 1'b0;
      sda_next         = 1'b0;
    end else if (byte_state) begin
      if (scl_rise) begin
        shift_next       = byte_in[6:0];
        bit_pending_next = 1'b1;
        bit_cnt_next     = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          bit_cnt_next     = 3'd0;
          bit_pending_next = 1'b0;
          case (state)
            ADDR: begin
              if (byte_in[7:1] == SLAVE_ADDRESS && !byte_in[0]) begin
                state_next  = ADDR_ACK;
                status_next = status | 8'h01;
              end else begin
                state_next  = IGNORE;
                status_next = status | 8'h08;
              end
            end
            REG: begin
              addr_next   = byte_in;
              state_next  = REG_ACK;
              status_next = status | 8'h02;
            end
            default: begin
              data_next   = byte_in;
              write_next  = 1'b1;
              state_next  = DATA_ACK;
              status_next = status | 8'h04;
            end
          endcase
        end
      end else if (scl_fall) begin
        bit_pending_next = 1'b0;
      end
    end else if ((state == ADDR_ACK || state == REG_ACK || state == DATA_ACK) && scl_fall) begin
      // First fall ends bit 7 and starts the ACK; second fall ends the ACK clock.
      if (!sda_drive_low) begin
        sda_next = 1'b1;
      end else begin
        sda_next   = 1'b0;
        state_next = (state == ADDR_ACK) ? REG : DATA;
        if (state == DATA_ACK) addr_next = reg_addr + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt       <= 3'd0;
      bit_pending   <= 1'b0;
      shift         <= 7'd0;
      sda_drive_low <= 1'b0;
      reg_addr      <= 8'd0;
      reg_data      <= 8'd0;
      reg_write     <= 1'b0;
      busy          <= 1'b0;
      status        <= 8'd0;
    end else begin
      bit_cnt       <= bit_cnt_next;
      bit_pending   <= bit_pending_next;
      shift         <= shift_next;
      sda_drive_low <= sda_next;
      reg_addr      <= addr_next;
      reg_data      <= data_next;
      reg_write     <= write_next;
      busy          <= busy_next;
      status        <= status_next;
    end
  end

endmodule
